// File: rtl/blitter_dma_controller_if.sv
// Bus bundle for the blitter DMA controller: CPU register port, graphics ROM read port and
// video RAM write port. The slave modport is the controller's view.
interface blitter_dma_controller_if;
    logic        REG_WE;
    logic [2:0]  REG_SEL;
    logic [7:0]  DIN;
    logic [15:0] GFX_ADDR;
    logic        GFX_RD;
    logic [7:0]  GFX_DATA;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_DATA;
    logic        VRAM_REQ;
    logic        VRAM_GNT;
    logic        VRAM_WE;
    logic        BUSY;
    logic        DONE;

    modport master (
        output REG_WE, REG_SEL, DIN, GFX_DATA, VRAM_GNT,
        input  GFX_ADDR, GFX_RD, VRAM_ADDR, VRAM_DATA, VRAM_REQ, VRAM_WE, BUSY, DONE
    );

    modport slave (
        input  REG_WE, REG_SEL, DIN, GFX_DATA, VRAM_GNT,
        output GFX_ADDR, GFX_RD, VRAM_ADDR, VRAM_DATA, VRAM_REQ, VRAM_WE, BUSY, DONE
    );
endinterface

// File: rtl/blitter_dma_controller.sv
// Blitter DMA: copies a linear run of graphics ROM bytes into a row-strided rectangle of
// video RAM, one byte per READ/CAPT/WRITE pass (3 cycles per byte with the grant held).
module blitter_dma_controller (
    input logic                     CPU_CLOCK,
    input logic                     FPGA_RESET,
    blitter_dma_controller_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRead, StCapt, StWrite} state_e;

    state_e      state_q, state_d;
    logic [7:0]  src_l_q, src_l_d;
    logic [7:0]  src_h_q, src_h_d;
    logic [7:0]  dst_l_q, dst_l_d;
    logic [5:0]  dst_h_q, dst_h_d;
    logic [7:0]  width_q, width_d;
    logic [7:0]  height_q, height_d;
    logic [15:0] src_ptr_q, src_ptr_d;
    logic [13:0] row_base_q, row_base_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [15:0] gfx_addr_q, gfx_addr_d;
    logic        gfx_rd_q, gfx_rd_d;
    logic [13:0] vram_addr_q, vram_addr_d;
    logic [7:0]  vram_data_q, vram_data_d;
    logic        vram_req_q, vram_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic reg_wr_ok;
    logic start;
    logic last_col;
    logic last_row;
    logic unused_din;

    // Only DST_H keeps the low six bits; the VRAM space is 16 KiB.
    assign unused_din = ^bus.DIN[7:6];

    assign reg_wr_ok = bus.REG_WE && !busy_q;
    assign start     = reg_wr_ok && (bus.REG_SEL == 3'd6);
    assign last_col  = (col_q == width_q);
    assign last_row  = (row_q == height_q);

    always_comb begin
        state_d     = state_q;
        src_l_d     = src_l_q;
        src_h_d     = src_h_q;
        dst_l_d     = dst_l_q;
        dst_h_d     = dst_h_q;
        width_d     = width_q;
        height_d    = height_q;
        src_ptr_d   = src_ptr_q;
        row_base_d  = row_base_q;
        col_d       = col_q;
        row_d       = row_q;
        gfx_addr_d  = gfx_addr_q;
        gfx_rd_d    = gfx_rd_q;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        vram_req_d  = vram_req_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (reg_wr_ok) begin
            case (bus.REG_SEL)
                3'd0:    src_l_d  = bus.DIN;
                3'd1:    src_h_d  = bus.DIN;
                3'd2:    dst_l_d  = bus.DIN;
                3'd3:    dst_h_d  = bus.DIN[5:0];
                3'd4:    width_d  = bus.DIN;
                3'd5:    height_d = bus.DIN;
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d  = {src_h_q, src_l_q};
                    row_base_d = {dst_h_q, dst_l_q};
                    col_d      = 8'd0;
                    row_d      = 8'd0;
                    busy_d     = 1'b1;
                    gfx_rd_d   = 1'b1;
                    gfx_addr_d = {src_h_q, src_l_q};
                    state_d    = StRead;
                end
            end
            StRead: begin
                gfx_rd_d  = 1'b0;
                src_ptr_d = src_ptr_q + 16'd1;
                state_d   = StCapt;
            end
            StCapt: begin
                vram_data_d = bus.GFX_DATA;
                vram_addr_d = row_base_q + 14'(col_q);
                vram_req_d  = 1'b1;
                state_d     = StWrite;
            end
            StWrite: begin
                // Address and data stay put for as long as the scan arbiter withholds the grant.
                if (bus.VRAM_GNT) begin
                    vram_req_d = 1'b0;
                    if (last_col && last_row) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        gfx_rd_d   = 1'b1;
                        gfx_addr_d = src_ptr_q;
                        state_d    = StRead;
                        if (last_col) begin
                            col_d      = 8'd0;
                            row_d      = row_q + 8'd1;
                            row_base_d = row_base_q + 14'd256;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CPU_CLOCK) begin
        if (FPGA_RESET) begin
            state_q     <= StIdle;
            src_l_q     <= 8'd0;
            src_h_q     <= 8'd0;
            dst_l_q     <= 8'd0;
            dst_h_q     <= 6'd0;
            width_q     <= 8'd0;
            height_q    <= 8'd0;
            src_ptr_q   <= 16'd0;
            row_base_q  <= 14'd0;
            col_q       <= 8'd0;
            row_q       <= 8'd0;
            gfx_addr_q  <= 16'd0;
            gfx_rd_q    <= 1'b0;
            vram_addr_q <= 14'd0;
            vram_data_q <= 8'd0;
            vram_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_l_q     <= src_l_d;
            src_h_q     <= src_h_d;
            dst_l_q     <= dst_l_d;
            dst_h_q     <= dst_h_d;
            width_q     <= width_d;
            height_q    <= height_d;
            src_ptr_q   <= src_ptr_d;
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
            gfx_addr_q  <= gfx_addr_d;
            gfx_rd_q    <= gfx_rd_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
            vram_req_q  <= vram_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.GFX_ADDR  = gfx_addr_q;
    assign bus.GFX_RD    = gfx_rd_q;
    assign bus.VRAM_ADDR = vram_addr_q;
    assign bus.VRAM_DATA = vram_data_q;
    assign bus.VRAM_REQ  = vram_req_q;
    // A reset in the grant cycle kills the strobe so an aborted transfer never lands a byte.
    assign bus.VRAM_WE   = vram_req_q && bus.VRAM_GNT && !FPGA_RESET;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_blitter_dma_controller.sv
// Directed bench for blitter_dma_controller: ROM model, VRAM write capture and per-scenario tasks.
module tb_blitter_dma_controller;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   start_cyc;
    int   done_cnt;

    logic [13:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [15:0] rd_addr[$];

    blitter_dma_controller_if bus ();

    blitter_dma_controller dut (
        .CPU_CLOCK  (clk),
        .FPGA_RESET (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.GFX_RD) begin
            bus.GFX_DATA <= rom(bus.GFX_ADDR);
            rd_addr.push_back(bus.GFX_ADDR);
        end
        if (bus.VRAM_WE) begin
            wr_addr.push_back(bus.VRAM_ADDR);
            wr_data.push_back(bus.VRAM_DATA);
        end
    end

    always @(negedge clk) if (bus.DONE === 1'b1) done_cnt <= done_cnt + 1;

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
    endtask

    task automatic reg_write(input logic [2:0] sel, input logic [7:0] data);
        @(negedge clk);
        bus.REG_WE  = 1'b1;
        bus.REG_SEL = sel;
        bus.DIN     = data;
        @(negedge clk);
        bus.REG_WE  = 1'b0;
    endtask

    task automatic program_regs(input logic [15:0] src, input logic [13:0] dst,
                                input logic [7:0] w, input logic [7:0] h);
        reg_write(3'd0, src[7:0]);
        reg_write(3'd1, src[15:8]);
        reg_write(3'd2, dst[7:0]);
        reg_write(3'd3, {2'b00, dst[13:8]});
        reg_write(3'd4, w);
        reg_write(3'd5, h);
    endtask

    // Leaves the bench at the negedge just after the accepting edge.
    task automatic do_start();
        @(negedge clk);
        bus.REG_WE  = 1'b1;
        bus.REG_SEL = 3'd6;
        bus.DIN     = 8'hFF;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        bus.REG_WE = 1'b0;
    endtask

    // Latency counts from the cycle carrying the START write to the cycle showing DONE.
    task automatic wait_done(output int lat);
        int guard = 0;
        while (bus.DONE !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        lat = (bus.DONE === 1'b1) ? (cyc - start_cyc + 1) : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b%b expected 00", bus.BUSY, bus.DONE);
        end
        n_cmp++;
        if (bus.GFX_RD !== 1'b0 || bus.VRAM_REQ !== 1'b0 || bus.VRAM_WE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b%b%b expected 000",
                     bus.GFX_RD, bus.VRAM_REQ, bus.VRAM_WE);
        end
        n_cmp++;
        if (bus.GFX_ADDR !== 16'h0 || bus.VRAM_ADDR !== 14'h0 || bus.VRAM_DATA !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h %h %h expected 0 0 0",
                     bus.GFX_ADDR, bus.VRAM_ADDR, bus.VRAM_DATA);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        bus.VRAM_GNT = 1'b1;
        program_regs(16'h1000, 14'h0100, 8'd1, 8'd0);
        clear_log();
        do_start();
        n_cmp++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_on_accept: got %b expected 1", bus.BUSY);
        end
        wait_done(lat);
        n_cmp++;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL basic_done_latency: got %0d expected 7", lat);
        end
        n_cmp++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done: got %b expected 0", bus.BUSY);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b expected 0", bus.DONE);
        end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d expected 2", wr_addr.size());
        end else if (wr_addr[0] !== 14'h0100 || wr_addr[1] !== 14'h0101 ||
                     wr_data[0] !== rom(16'h1000) || wr_data[1] !== rom(16'h1001)) begin
            n_fail++;
            $display("FAIL basic_writes: got %h/%h %h/%h expected 0100/%h 0101/%h",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1],
                     rom(16'h1000), rom(16'h1001));
        end
    endtask

    task automatic test_dst_wrap();
        int lat;
        program_regs(16'h0040, 14'h3FFF, 8'd0, 8'd1);
        clear_log();
        do_start();
        wait_done(lat);
        n_cmp++;
        if (lat != 7) begin
            n_fail++;
            $display("FAIL dst_wrap_latency: got %0d expected 7", lat);
        end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL dst_wrap_count: got %0d expected 2", wr_addr.size());
        end else if (wr_addr[0] !== 14'h3FFF || wr_addr[1] !== 14'h00FF) begin
            n_fail++;
            $display("FAIL dst_wrap_addr: got %h %h expected 3fff 00ff", wr_addr[0], wr_addr[1]);
        end
    endtask

    task automatic test_src_wrap();
        int lat;
        program_regs(16'hFFFF, 14'h0200, 8'd1, 8'd0);
        clear_log();
        do_start();
        wait_done(lat);
        n_cmp++;
        if (rd_addr.size() != 2) begin
            n_fail++;
            $display("FAIL src_wrap_count: got %0d expected 2", rd_addr.size());
        end else if (rd_addr[0] !== 16'hFFFF || rd_addr[1] !== 16'h0000) begin
            n_fail++;
            $display("FAIL src_wrap_addr: got %h %h expected ffff 0000", rd_addr[0], rd_addr[1]);
        end
        n_cmp++;
        if (wr_data.size() != 2) begin
            n_fail++;
            $display("FAIL src_wrap_wcount: got %0d expected 2", wr_data.size());
        end else if (wr_data[0] !== rom(16'hFFFF) || wr_data[1] !== rom(16'h0000)) begin
            n_fail++;
            $display("FAIL src_wrap_data: got %h %h expected %h %h",
                     wr_data[0], wr_data[1], rom(16'hFFFF), rom(16'h0000));
        end
    endtask

    task automatic test_gnt_stall();
        int lat;
        program_regs(16'h1000, 14'h0100, 8'd1, 8'd0);
        clear_log();
        bus.VRAM_GNT = 1'b0;
        fork
            begin
                do_start();
                wait_done(lat);
            end
            begin
                int g = 0;
                @(negedge clk);
                while (bus.VRAM_REQ !== 1'b1 && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                for (int i = 0; i < 5; i++) begin
                    n_cmp++;
                    if (bus.VRAM_REQ !== 1'b1 || bus.VRAM_WE !== 1'b0 ||
                        bus.VRAM_ADDR !== 14'h0100 || bus.VRAM_DATA !== rom(16'h1000)) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: got req=%b we=%b %h/%h expected 1 0 0100/%h",
                                 i, bus.VRAM_REQ, bus.VRAM_WE, bus.VRAM_ADDR, bus.VRAM_DATA,
                                 rom(16'h1000));
                    end
                    @(negedge clk);
                end
                bus.VRAM_GNT = 1'b1;
            end
        join
        n_cmp++;
        if (lat != 12) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 12", lat);
        end
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL stall_write_count: got %0d expected 2", wr_addr.size());
        end else if (wr_addr[0] !== 14'h0100 || wr_data[0] !== rom(16'h1000)) begin
            n_fail++;
            $display("FAIL stall_first_write: got %h/%h expected 0100/%h",
                     wr_addr[0], wr_data[0], rom(16'h1000));
        end
    endtask

    task automatic test_busy_writes();
        int lat;
        int d0;
        program_regs(16'h2000, 14'h0200, 8'd3, 8'd0);
        clear_log();
        d0 = done_cnt;
        do_start();
        reg_write(3'd0, 8'h55);
        reg_write(3'd6, 8'h00);
        wait_done(lat);
        n_cmp++;
        if (lat != 13) begin
            n_fail++;
            $display("FAIL busy_first_latency: got %0d expected 13", lat);
        end
        @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL busy_done_pulses: got %0d expected %0d", done_cnt - d0, 1);
        end
        clear_log();
        do_start();
        wait_done(lat);
        n_cmp++;
        if (rd_addr.size() != 4 || rd_addr[0] !== 16'h2000 || rd_addr[3] !== 16'h2003) begin
            n_fail++;
            $display("FAIL busy_src_kept: got n=%0d first=%h expected n=4 first=2000",
                     rd_addr.size(), (rd_addr.size() > 0) ? rd_addr[0] : 16'hxxxx);
        end
        n_cmp++;
        if (wr_addr.size() != 4 || wr_addr[3] !== 14'h0203) begin
            n_fail++;
            $display("FAIL busy_repeat_writes: got n=%0d expected n=4 last=0203", wr_addr.size());
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int g = 0;
        int n_wr;
        int d0;
        program_regs(16'h3000, 14'h0400, 8'd3, 8'd3);
        clear_log();
        d0 = done_cnt;
        do_start();
        while (wr_addr.size() < 5 && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (wr_addr.size() < 5 || wr_addr[4] !== 14'h0500) begin
            n_fail++;
            $display("FAIL abort_row1_reached: got n=%0d expected row 1 write at 0500",
                     wr_addr.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_wr = wr_addr.size();
        n_cmp++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.GFX_RD !== 1'b0 ||
            bus.VRAM_REQ !== 1'b0 || bus.VRAM_WE !== 1'b0 || bus.GFX_ADDR !== 16'h0 ||
            bus.VRAM_ADDR !== 14'h0 || bus.VRAM_DATA !== 8'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b rd=%b req=%b we=%b %h %h %h exp 0",
                     bus.BUSY, bus.DONE, bus.GFX_RD, bus.VRAM_REQ, bus.VRAM_WE,
                     bus.GFX_ADDR, bus.VRAM_ADDR, bus.VRAM_DATA);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() != n_wr || done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_quiet: got writes+%0d done=%0d expected 0 0",
                     wr_addr.size() - n_wr, done_cnt - d0);
        end
        clear_log();
        do_start();
        wait_done(lat);
        n_cmp++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL abort_regs_latency: got %0d expected 4", lat);
        end
        n_cmp++;
        if (wr_addr.size() != 1 || rd_addr.size() != 1) begin
            n_fail++;
            $display("FAIL abort_regs_count: got w=%0d r=%0d expected 1 1",
                     wr_addr.size(), rd_addr.size());
        end else if (wr_addr[0] !== 14'h0 || rd_addr[0] !== 16'h0 || wr_data[0] !== rom(16'h0)) begin
            n_fail++;
            $display("FAIL abort_regs_zero: got %h<-%h data %h expected 0000<-0000 data %h",
                     wr_addr[0], rd_addr[0], wr_data[0], rom(16'h0));
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        start_cyc    = 0;
        done_cnt     = 0;
        rst          = 1'b1;
        bus.REG_WE   = 1'b0;
        bus.REG_SEL  = 3'd0;
        bus.DIN      = 8'h00;
        bus.GFX_DATA = 8'h00;
        bus.VRAM_GNT = 1'b1;
        test_reset();
        test_basic();
        test_dst_wrap();
        test_src_wrap();
        test_gnt_stall();
        test_busy_writes();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/blitter_dma_controller.md
BLITTER_DMA_CONTROLLER -- requirements
Module: blitter_dma_controller

Interface
REQ-001 SHALL have port CPU_CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port FPGA_RESET  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port REG_WE  in  1  decoded register-write strobe, active-high, one cycle per CPU write.
REQ-004 SHALL have port REG_SEL  in  3  register select (AB2..AB0).
REQ-005 SHALL have port DIN  in  8  CPU data bus (DB7..DB0).
REQ-006 SHALL have port GFX_ADDR  out  16  graphics ROM byte address.
REQ-007 SHALL have port GFX_RD  out  1  ROM read request; GFX_DATA is valid the cycle after.
REQ-008 SHALL have port GFX_DATA  in  8  ROM read data.
REQ-009 SHALL have port VRAM_ADDR  out  14  video RAM write address.
REQ-010 SHALL have port VRAM_DATA  out  8  video RAM write data.
REQ-011 SHALL have port VRAM_REQ  out  1  request for the VRAM port.
REQ-012 SHALL have port VRAM_GNT  in  1  grant from video-scan arbiter; may be low for any number of cycles.
REQ-013 SHALL have port VRAM_WE  out  1  VRAM write strobe, high only when VRAM_REQ and VRAM_GNT both high.
REQ-014 SHALL have port BUSY  out  1  high from START accept until after the last write.
REQ-015 SHALL have port DONE  out  1  single-cycle pulse on completion.

Function
REQ-016 Register map SHALL be: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H[5:0], 4 WIDTH, 5 HEIGHT, 6 START (data ignored), 7 unused (writes ignored).
REQ-017 Register writes SHALL take effect the cycle after REG_WE; all writes, including START, SHALL be ignored while BUSY=1.
REQ-018 Transfer size SHALL be (WIDTH+1) columns x (HEIGHT+1) rows; WIDTH=0/HEIGHT=0 means 1; max 256x256.
REQ-019 Source SHALL be linear: src increments by 1 per byte, wrapping 0xFFFF->0x0000.
REQ-020 Destination SHALL be row-strided: column c, row r -> (DST + r*256 + c) mod 2^14; row start advances by 256.
REQ-021 FSM states SHALL be IDLE, READ, CAPT, WRITE.
REQ-022 IDLE: on accepted START, load counters from registers, BUSY=1, next READ.
REQ-023 READ: GFX_RD=1, GFX_ADDR=src, next CAPT.
REQ-024 CAPT: latch GFX_DATA into VRAM_DATA, next WRITE.
REQ-025 WRITE: VRAM_REQ=1 with VRAM_ADDR/VRAM_DATA stable; hold while VRAM_GNT=0; on VRAM_GNT=1 assert VRAM_WE for that cycle and advance.
REQ-026 Advance: if last column of last row -> IDLE, BUSY=0 and DONE=1 next cycle; else if last column -> column=0, row+1, next READ; else column+1, next READ.
REQ-027 Minimum throughput SHALL be 3 cycles per byte with VRAM_GNT held high.
REQ-028 GFX_RD, VRAM_REQ and VRAM_WE SHALL be low in IDLE; START and write completion in the same cycle cannot coincide (START ignored while BUSY).
REQ-029 Programmed registers SHALL retain values after a transfer so START alone repeats it.

Reset
REQ-030 On FPGA_RESET=1, next edge: state IDLE; all registers, counters, VRAM_DATA, GFX_ADDR, VRAM_ADDR = 0; BUSY, DONE, GFX_RD, VRAM_REQ, VRAM_WE = 0.
REQ-031 Reset mid-transfer SHALL abort immediately: no further VRAM_WE, no DONE pulse.

Verification
REQ-032 SRC=0x1000, DST=0x0100, WIDTH=1, HEIGHT=0, GNT=1, START -> writes 0x0100, 0x0101 with ROM[0x1000], ROM[0x1001]; DONE 7 cycles after START accept.
REQ-033 DST=0x3FFF, WIDTH=0, HEIGHT=1 -> writes 0x3FFF then 0x00FF (14-bit wrap).
REQ-034 SRC=0xFFFF, WIDTH=1, HEIGHT=0 -> ROM reads 0xFFFF then 0x0000.
REQ-035 GNT low 5 cycles during first WRITE -> VRAM_REQ held, address/data stable, one VRAM_WE only after GNT rises; total 5 cycles longer.
REQ-036 Writes to SRC_L and START while BUSY -> no effect; next transfer uses old SRC_L.
REQ-037 FPGA_RESET during row 1 of a 4x4 transfer -> all outputs 0 next cycle, no DONE, registers read back 0 (transfer with START alone copies one byte from 0x0000).
